epb_master: RTL
===============

Name: epb_master

Overview:
- EPB initiator: turns a single-outstanding request/response interface into EPB bus cycles.
- Drives chip select, output enable, read/write, byte enables, address, general-purpose address and data, then waits for the target's ready.
- Sits on the opposite side of the EPB pad layer from the FPGA-side target. Used to reach EPB peripherals and as a bus-functional driver in system benches.

Parameters:
SETUP_CYCLES, 1, cycles addr/r_w_n/be_n/write data are driven before cs_n falls (minimum 1)
HOLD_CYCLES, 1, cycles addr/data stay driven after cs_n rises (minimum 1)
TIMEOUT_CYCLES, 255, maximum cycles cs_n is held low waiting for epb_rdy (minimum 1)

Ports:
clk  in  1  system clock; all logic is on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_rnw  in  1  1 = read, 0 = write
req_addr  in  23  word address
req_addr_gp  in  6  general-purpose address bits
req_be  in  2  byte enables, active high
req_wdata  in  16  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  completion was a timeout; valid with rsp_valid
rsp_rdata  out  16  read data; valid with rsp_valid
epb_cs_n  out  1  chip select, active low
epb_oe_n  out  1  output enable, active low, reads only
epb_r_w_n  out  1  1 = read, 0 = write
epb_be_n  out  2  byte enables, active low
epb_addr  out  23  address
epb_addr_gp  out  6  general-purpose address
epb_data_out  out  16  write data to pad
epb_data_oe_n  out  1  data pad tristate control; 0 = drive
epb_data_in  in  16  data from pad
epb_rdy  in  1  target ready, active high

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, applied immediately on rst and held while rst is high:
  - epb_cs_n = 1, epb_oe_n = 1, epb_r_w_n = 1, epb_be_n = 2'b11, epb_data_oe_n = 1
  - epb_addr = 0, epb_addr_gp = 0, epb_data_out = 0
  - req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0
  - state = IDLE
- All outputs are registered. req_ready rises on the first clk edge after rst deasserts.
- State machine: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch all request fields.
  - Drive epb_addr, epb_addr_gp, epb_r_w_n = req_rnw and epb_be_n = ~req_be.
  - For writes, also drive epb_data_out and set epb_data_oe_n = 0.
  - req_ready = 0 on the next cycle. Go to SETUP.
- SETUP: hold for SETUP_CYCLES cycles with cs_n = 1, then go to STROBE.
- STROBE:
  - epb_cs_n = 0. epb_oe_n = 0 when reading, 1 when writing.
  - epb_rdy is sampled every cycle. On rdy = 1: capture epb_data_in into rsp_rdata (reads only; writes return 0) and go to HOLD.
  - A timeout counter counts cycles spent in STROBE. When it reaches TIMEOUT_CYCLES without rdy: set the error flag, rsp_rdata = 0, go to HOLD.
  - If rdy and timeout occur in the same cycle, rdy wins and no error is flagged.
- HOLD:
  - epb_cs_n = 1 and epb_oe_n = 1 from the first HOLD cycle.
  - addr, be_n, r_w_n and write data remain driven for HOLD_CYCLES cycles.
- RESP:
  - rsp_valid = 1 for exactly one cycle; rsp_err reflects the timeout flag.
  - Bus returns to reset values: epb_data_oe_n = 1, be_n = 2'b11, r_w_n = 1.
  - Go to IDLE.
- Latency, from the accept edge T0 to the rsp_valid cycle: SETUP_CYCLES + (STROBE cycles) + HOLD_CYCLES + 1. With defaults and immediate rdy, rsp_valid is high in cycle T0+4 and req_ready is high again in cycle T0+5.
- No request is accepted while a transaction is in progress; req_valid is ignored outside IDLE.
- epb_data_oe_n is never 0 during a read, and epb_oe_n is never 0 during a write.
- Reset mid-transaction aborts the cycle: outputs go to reset values asynchronously and no rsp_valid is emitted.

Optional Feature:
- Macro: EPB_MASTER_RDY_SYNC_EN.
- Defined: epb_rdy passes through a two-flop synchronizer before use. The rdy-to-HOLD response is delayed by 2 cycles, and the timeout counts synchronized cycles.
- Undefined: epb_rdy is treated as synchronous to clk and sampled directly.

Test Plan:
- Write addr 0x12345, gp 0x2A, be 2'b11, data 0xBEEF, rdy high at first STROBE cycle:
  - epb_r_w_n = 0, epb_be_n = 00, epb_data_oe_n = 0 from T0+1, cs_n low for 1 cycle, oe_n stays 1.
  - rsp_valid at T0+4 with rsp_err = 0.
- Read addr 0x7FFFFF, target returns 0xA5C3 with rdy after 3 wait cycles:
  - epb_oe_n = 0 while cs_n is low, data_oe_n stays 1.
  - rsp_rdata = 0xA5C3 at T0+7.
- Read with rdy never asserted and TIMEOUT_CYCLES = 4:
  - cs_n low for exactly 4 cycles, then rsp_valid = 1 with rsp_err = 1 and rsp_rdata = 0.
- Assert rst during STROBE of a write:
  - cs_n = 1 and data_oe_n = 1 immediately, no rsp_valid.
  - req_ready = 1 one edge after rst releases.
- Back-to-back write then read with req_valid held high:
  - Second request is accepted only when req_ready = 1 after RESP.
  - cs_n shows two distinct low pulses separated by at least HOLD_CYCLES + SETUP_CYCLES + 1 high cycles.
- rdy asserted on the same cycle the timeout expires (TIMEOUT_CYCLES = 2):
  - rsp_err = 0 and the data is captured.

Source files
------------

// File: rtl/epb_master.sv
// ---------------------------------------------------------------------------
// epb_master
//
// EPB initiator. Turns a single-outstanding request/response interface into
// one EPB bus cycle per request: address phase (SETUP), chip-select phase
// waiting for the target's ready (STROBE), address/data hold (HOLD), and a
// one-cycle completion pulse (RESP). Every output comes straight from a flop.
//
// Parameters
//   SETUP_CYCLES   cycles the address/data are driven before cs_n falls (>= 1)
//   HOLD_CYCLES    cycles the address/data stay driven after cs_n rises (>= 1)
//   TIMEOUT_CYCLES maximum cycles cs_n stays low waiting for epb_rdy (>= 1)
//
// Optional build macro
//   EPB_MASTER_RDY_SYNC_EN  when defined, epb_rdy goes through a two-flop
//                           synchronizer before the state machine sees it;
//                           otherwise epb_rdy is sampled directly.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req_valid/ready   request handshake
//   req_rnw           1 = read, 0 = write
//   req_addr[22:0]    word address
//   req_addr_gp[5:0]  general-purpose address bits
//   req_be[1:0]       byte enables, active high
//   req_wdata[15:0]   write data
//   rsp_valid         one-cycle completion pulse
//   rsp_err           completion was a timeout (valid with rsp_valid)
//   rsp_rdata[15:0]   read data (valid with rsp_valid)
//   epb_cs_n, epb_oe_n, epb_r_w_n, epb_be_n[1:0]   bus strobes (active low)
//   epb_addr[22:0], epb_addr_gp[5:0]               bus address
//   epb_data_out[15:0], epb_data_oe_n              write data and pad enable
//   epb_data_in[15:0], epb_rdy                     read data and target ready
// ---------------------------------------------------------------------------
module epb_master #(
  parameter int SETUP_CYCLES   = 1,
  parameter int HOLD_CYCLES    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rnw,
  input  logic [22:0] req_addr,
  input  logic [5:0]  req_addr_gp,
  input  logic [1:0]  req_be,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_rdata,
  output logic        epb_cs_n,
  output logic        epb_oe_n,
  output logic        epb_r_w_n,
  output logic [1:0]  epb_be_n,
  output logic [22:0] epb_addr,
  output logic [5:0]  epb_addr_gp,
  output logic [15:0] epb_data_out,
  output logic        epb_data_oe_n,
  input  logic [15:0] epb_data_in,
  input  logic        epb_rdy
);

  localparam int MAX_SH     = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int MAX_CYCLES = (MAX_SH > TIMEOUT_CYCLES) ? MAX_SH : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rnw;
  logic              r_err;
  logic              w_rnw;
  logic              w_err;
  logic              w_rdy;
  logic              w_accept;

  logic              r_reqReady,  w_reqReady;
  logic              r_rspValid,  w_rspValid;
  logic              r_rspErr,    w_rspErr;
  logic [15:0]       r_rspRdata,  w_rspRdata;
  logic              r_csN,       w_csN;
  logic              r_oeN,       w_oeN;
  logic              r_rwN,       w_rwN;
  logic [1:0]        r_beN,       w_beN;
  logic [22:0]       r_addr,      w_addr;
  logic [5:0]        r_addrGp,    w_addrGp;
  logic [15:0]       r_dataOut,   w_dataOut;
  logic              r_dataOeN,   w_dataOeN;

`ifdef EPB_MASTER_RDY_SYNC_EN
  logic r_rdyMeta;
  logic r_rdySync;

  // Two-flop synchronizer for a ready that comes from another clock domain.
  // The state machine only ever looks at the second stage, so the response
  // to a rising ready and the timeout both run on synchronized cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdyMeta <= 1'b0;
      r_rdySync <= 1'b0;
    end else begin
      r_rdyMeta <= epb_rdy;
      r_rdySync <= r_rdyMeta;
    end
  end

  assign w_rdy = r_rdySync;
`else
  assign w_rdy = epb_rdy;
`endif

  assign w_accept = (r_state == IDLE) && req_valid && r_reqReady;

  // State register. It also holds the per-state cycle counter (cleared on
  // every state change) and the registered copies of every output, which are
  // loaded from the next-value terms worked out by the output logic below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_rnw      <= 1'b1;
      r_err      <= 1'b0;
      r_reqReady <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspErr   <= 1'b0;
      r_rspRdata <= '0;
      r_csN      <= 1'b1;
      r_oeN      <= 1'b1;
      r_rwN      <= 1'b1;
      r_beN      <= 2'b11;
      r_addr     <= '0;
      r_addrGp   <= '0;
      r_dataOut  <= '0;
      r_dataOeN  <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_cnt      <= (w_nextState != r_state) ? '0 : r_cnt + CNT_W'(1);
      r_rnw      <= w_rnw;
      r_err      <= w_err;
      r_reqReady <= w_reqReady;
      r_rspValid <= w_rspValid;
      r_rspErr   <= w_rspErr;
      r_rspRdata <= w_rspRdata;
      r_csN      <= w_csN;
      r_oeN      <= w_oeN;
      r_rwN      <= w_rwN;
      r_beN      <= w_beN;
      r_addr     <= w_addr;
      r_addrGp   <= w_addrGp;
      r_dataOut  <= w_dataOut;
      r_dataOeN  <= w_dataOeN;
    end
  end

  // Next-state logic. SETUP and HOLD simply count out their cycles. STROBE
  // leaves on ready or when the counter shows the last allowed cycle; if both
  // happen together the cycle still leaves normally and ready decides the
  // outcome (see the output logic).
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = SETUP;
      SETUP:   if (r_cnt == SETUP_LAST) w_nextState = STROBE;
      STROBE:  if (w_rdy || (r_cnt == TIMEOUT_LAST)) w_nextState = HOLD;
      HOLD:    if (r_cnt == HOLD_LAST) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs. Everything holds
  // its value except on the transitions that change the bus. Because these
  // are loaded on the same edge as the state change, the bus pins line up
  // exactly with the state the machine is entering. Ready and the response
  // pulse are pure functions of the state being entered.
  always_comb begin
    w_rnw      = r_rnw;
    w_err      = r_err;
    w_reqReady = (w_nextState == IDLE);
    w_rspValid = (w_nextState == RESP);
    w_rspErr   = (w_nextState == RESP) ? r_err : 1'b0;
    w_rspRdata = r_rspRdata;
    w_csN      = r_csN;
    w_oeN      = r_oeN;
    w_rwN      = r_rwN;
    w_beN      = r_beN;
    w_addr     = r_addr;
    w_addrGp   = r_addrGp;
    w_dataOut  = r_dataOut;
    w_dataOeN  = r_dataOeN;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_rnw     = req_rnw;
          w_err     = 1'b0;
          w_addr    = req_addr;
          w_addrGp  = req_addr_gp;
          w_rwN     = req_rnw;
          w_beN     = ~req_be;
          w_dataOeN = req_rnw;
          if (!req_rnw) w_dataOut = req_wdata;
        end
      end
      SETUP: begin
        if (w_nextState == STROBE) begin
          w_csN = 1'b0;
          w_oeN = ~r_rnw;
        end
      end
      STROBE: begin
        if (w_nextState == HOLD) begin
          w_csN      = 1'b1;
          w_oeN      = 1'b1;
          w_err      = ~w_rdy;
          w_rspRdata = (w_rdy && r_rnw) ? epb_data_in : 16'h0000;
        end
      end
      HOLD: begin
        if (w_nextState == RESP) begin
          w_dataOeN = 1'b1;
          w_beN     = 2'b11;
          w_rwN     = 1'b1;
        end
      end
      RESP: begin
      end
      default: begin
      end
    endcase
  end

  assign req_ready     = r_reqReady;
  assign rsp_valid     = r_rspValid;
  assign rsp_err       = r_rspErr;
  assign rsp_rdata     = r_rspRdata;
  assign epb_cs_n      = r_csN;
  assign epb_oe_n      = r_oeN;
  assign epb_r_w_n     = r_rwN;
  assign epb_be_n      = r_beN;
  assign epb_addr      = r_addr;
  assign epb_addr_gp   = r_addrGp;
  assign epb_data_out  = r_dataOut;
  assign epb_data_oe_n = r_dataOeN;

endmodule
